// File: rtl/hetic_arbiter.sv
// hetic_arbiter
//   Picks the highest-priority pending, enabled interrupt line whose
//   priority is strictly above the core's current level. The line is
//   offered to the core. When the core acknowledges it, a one-cycle ip-clear
//   pulse goes back to the line register file.
//
//   Two-stage tree: stage 1 reduces each GroupSize-line group to one
//   candidate, and stage 2 reduces the group winners. On equal priority
//   the lowest line index wins at both stages.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   line_ie_i           per-line enable
//   line_ip_i           per-line pending
//   line_prio_i         per-line priority, line n at [n*PrioWidth +: PrioWidth]
//   line_heti_i         per-line HETI mode flag
//   line_nest_i         per-line nesting-allowed flag
//   level_i             current core interrupt level (strict threshold)
//   irq_valid_o         interrupt offered to the core
//   irq_id_o/prio_o     offered line index / priority (0 when not valid)
//   irq_heti_o/nest_o   offered line flags (0 when not valid)
//   irq_ack_i, irq_id_i core claim strobe and claimed id
//   ip_clr_o            one-hot, one-cycle ip-clear request
module hetic_arbiter #(
  parameter  int unsigned NrIrqLines = 64,
  parameter  int unsigned NrIrqPrios = 32,
  parameter  int unsigned GroupSize  = 8,
  localparam int unsigned IrqWidth   = $clog2(NrIrqLines),
  localparam int unsigned PrioWidth  = $clog2(NrIrqPrios)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrIrqLines-1:0]           line_ie_i,
  input  logic [NrIrqLines-1:0]           line_ip_i,
  input  logic [NrIrqLines*PrioWidth-1:0] line_prio_i,
  input  logic [NrIrqLines-1:0]           line_heti_i,
  input  logic [NrIrqLines-1:0]           line_nest_i,
  input  logic [PrioWidth-1:0]            level_i,
  output logic                            irq_valid_o,
  output logic [IrqWidth-1:0]             irq_id_o,
  output logic [PrioWidth-1:0]            irq_prio_o,
  output logic                            irq_heti_o,
  output logic                            irq_nest_o,
  input  logic                            irq_ack_i,
  input  logic [IrqWidth-1:0]             irq_id_i,
  output logic [NrIrqLines-1:0]           ip_clr_o
);

  localparam int unsigned NrGroups = (NrIrqLines + GroupSize - 1) / GroupSize;
  localparam int unsigned PadLines = NrGroups * GroupSize;
  localparam int unsigned LocWidth = (GroupSize > 1) ? $clog2(GroupSize) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Eligibility and per-line fields, zero-padded to whole groups
  logic [PadLines-1:0]                w_elig;
  logic [PadLines-1:0][PrioWidth-1:0] w_prio_pad;
  logic [PadLines-1:0]                w_heti_pad;
  logic [PadLines-1:0]                w_nest_pad;

  always_comb begin
    w_elig     = '0;
    w_prio_pad = '0;
    w_heti_pad = '0;
    w_nest_pad = '0;
    for (int unsigned n = 0; n < NrIrqLines; n++) begin
      w_prio_pad[n] = line_prio_i[n*PrioWidth +: PrioWidth];
      w_heti_pad[n] = line_heti_i[n];
      w_nest_pad[n] = line_nest_i[n];
      // Strict compare also excludes prio 0, since level_i >= 0
      w_elig[n]     = line_ie_i[n] & line_ip_i[n] &
                      (line_prio_i[n*PrioWidth +: PrioWidth] > level_i);
    end
  end

  // Stage 1: per-group winner
  logic [NrGroups-1:0]                w_s1_found;
  logic [NrGroups-1:0][LocWidth-1:0]  w_s1_idx;
  logic [NrGroups-1:0][PrioWidth-1:0] w_s1_prio;
  logic [NrGroups-1:0]                w_s1_heti;
  logic [NrGroups-1:0]                w_s1_nest;

  always_comb begin
    w_s1_found = '0;
    w_s1_idx   = '0;
    w_s1_prio  = '0;
    w_s1_heti  = '0;
    w_s1_nest  = '0;
    for (int unsigned g = 0; g < NrGroups; g++) begin
      for (int unsigned l = 0; l < GroupSize; l++) begin
        // Strictly greater keeps the earliest (lowest) index on ties
        if (w_elig[g*GroupSize + l] &&
            (!w_s1_found[g] || (w_prio_pad[g*GroupSize + l] > w_s1_prio[g]))) begin
          w_s1_found[g] = 1'b1;
          w_s1_idx[g]   = l[LocWidth-1:0];
          w_s1_prio[g]  = w_prio_pad[g*GroupSize + l];
          w_s1_heti[g]  = w_heti_pad[g*GroupSize + l];
          w_s1_nest[g]  = w_nest_pad[g*GroupSize + l];
        end
      end
    end
  end

  logic [NrGroups-1:0]                r_s1_found;
  logic [NrGroups-1:0][LocWidth-1:0]  r_s1_idx;
  logic [NrGroups-1:0][PrioWidth-1:0] r_s1_prio;
  logic [NrGroups-1:0]                r_s1_heti;
  logic [NrGroups-1:0]                r_s1_nest;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_found <= '0;
      r_s1_idx   <= '0;
      r_s1_prio  <= '0;
      r_s1_heti  <= '0;
      r_s1_nest  <= '0;
    end else begin
      r_s1_found <= w_s1_found;
      r_s1_idx   <= w_s1_idx;
      r_s1_prio  <= w_s1_prio;
      r_s1_heti  <= w_s1_heti;
      r_s1_nest  <= w_s1_nest;
    end
  end

  // Stage 2: winner across groups
  logic                 w_s2_found;
  logic [IrqWidth-1:0]  w_s2_id;
  logic [PrioWidth-1:0] w_s2_prio;
  logic                 w_s2_heti;
  logic                 w_s2_nest;

  always_comb begin
    w_s2_found = 1'b0;
    w_s2_id    = '0;
    w_s2_prio  = '0;
    w_s2_heti  = 1'b0;
    w_s2_nest  = 1'b0;
    for (int unsigned g = 0; g < NrGroups; g++) begin
      if (r_s1_found[g] && (!w_s2_found || (r_s1_prio[g] > w_s2_prio))) begin
        w_s2_found = 1'b1;
        w_s2_id    = IrqWidth'(g*GroupSize + 32'(r_s1_idx[g]));
        w_s2_prio  = r_s1_prio[g];
        w_s2_heti  = r_s1_heti[g];
        w_s2_nest  = r_s1_nest[g];
      end
    end
  end

  // Offer FSM. The output registers are the stage-2 winner register,
  // gated by state. So an input change is visible two edges later, and
  // the outputs read as zero whenever nothing is offered.
  state_e                r_state;
  logic                  r_flush_cnt;
  logic                  r_valid;
  logic [IrqWidth-1:0]   r_id;
  logic [PrioWidth-1:0]  r_prio;
  logic                  r_heti;
  logic                  r_nest;
  logic [NrIrqLines-1:0] r_ip_clr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_flush_cnt <= 1'b0;
      r_valid     <= 1'b0;
      r_id        <= '0;
      r_prio      <= '0;
      r_heti      <= 1'b0;
      r_nest      <= 1'b0;
      r_ip_clr    <= '0;
    end else begin
      r_ip_clr <= '0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_prio   <= '0;
      r_heti   <= 1'b0;
      r_nest   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_s2_found) begin
            r_state <= OFFER;
            r_valid <= 1'b1;
            r_id    <= w_s2_id;
            r_prio  <= w_s2_prio;
            r_heti  <= w_s2_heti;
            r_nest  <= w_s2_nest;
          end
        end
        OFFER: begin
          if (irq_ack_i) begin
            // Ack wins over any simultaneous new winner; the core's id is authoritative
            r_state     <= FLUSH;
            r_flush_cnt <= 1'b0;
            if (32'(irq_id_i) < NrIrqLines) begin
              r_ip_clr[irq_id_i] <= 1'b1;
            end
          end else if (w_s2_found) begin
            r_valid <= 1'b1;
            r_id    <= w_s2_id;
            r_prio  <= w_s2_prio;
            r_heti  <= w_s2_heti;
            r_nest  <= w_s2_nest;
          end else begin
            r_state <= IDLE;
          end
        end
        FLUSH: begin
          // Two quiet cycles let the cleared ip reach the stage-2 result
          if (!r_flush_cnt) begin
            r_flush_cnt <= 1'b1;
          end else if (w_s2_found) begin
            r_state <= OFFER;
            r_valid <= 1'b1;
            r_id    <= w_s2_id;
            r_prio  <= w_s2_prio;
            r_heti  <= w_s2_heti;
            r_nest  <= w_s2_nest;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign irq_valid_o = r_valid;
  assign irq_id_o    = r_id;
  assign irq_prio_o  = r_prio;
  assign irq_heti_o  = r_heti;
  assign irq_nest_o  = r_nest;
  assign ip_clr_o    = r_ip_clr;

endmodule

// File: tb/tb_hetic_arbiter.sv
// Testbench for hetic_arbiter: directed scenarios followed by randomized
// traffic. The bench acts as the line register file. A reference model at
// each clock edge pushes the expected outputs into a queue, and a monitor on
// the falling edge pops and compares them.
// 60 lines are used so that out-of-range claim ids (60..63) can be driven
// and the last group contains padded lines.
module tb_hetic_arbiter;

  localparam int NL = 60;
  localparam int PW = 5;
  localparam int IW = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [NL-1:0]  ie, ip, heti, nest;
  logic [PW-1:0]  prio [NL];
  logic [NL*PW-1:0] prio_flat;
  logic [PW-1:0]  level;
  logic           ack;
  logic [IW-1:0]  ack_id;

  logic           irq_valid;
  logic [IW-1:0]  irq_id;
  logic [PW-1:0]  irq_prio;
  logic           irq_heti, irq_nest;
  logic [NL-1:0]  ip_clr;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    prio_flat = '0;
    for (int i = 0; i < NL; i++) prio_flat[i*PW +: PW] = prio[i];
  end

  hetic_arbiter #(.NrIrqLines(60), .NrIrqPrios(32), .GroupSize(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .line_ie_i(ie), .line_ip_i(ip), .line_prio_i(prio_flat),
    .line_heti_i(heti), .line_nest_i(nest), .level_i(level),
    .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_prio_o(irq_prio),
    .irq_heti_o(irq_heti), .irq_nest_o(irq_nest),
    .irq_ack_i(ack), .irq_id_i(ack_id), .ip_clr_o(ip_clr)
  );

  typedef struct packed {
    logic [NL-1:0]    ie, ip, heti, nest;
    logic [NL*PW-1:0] prio;
    logic [PW-1:0]    level;
  } snap_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
    logic [PW-1:0] prio;
    logic          heti, nest;
    logic [NL-1:0] clr;
  } exp_t;

  // Global winner: highest priority above level, lowest index on ties
  function automatic exp_t pick(snap_t s);
    exp_t r;
    logic [PW-1:0] p;
    r = '0;
    for (int n = 0; n < NL; n++) begin
      p = s.prio[n*PW +: PW];
      if (s.ie[n] && s.ip[n] && p > s.level && (!r.valid || p > r.prio)) begin
        r.valid = 1'b1;
        r.id    = IW'(n);
        r.prio  = p;
        r.heti  = s.heti[n];
        r.nest  = s.nest[n];
      end
    end
    return r;
  endfunction

  // Reference model: the offer seen after an edge reflects the inputs
  // that were present one edge earlier
  typedef enum {M_IDLE, M_OFFER, M_FLUSH} mstate_e;
  exp_t    exp_q[$];
  snap_t   prev;
  bit      prev_ok = 1'b0;
  mstate_e ms = M_IDLE;
  int      fl = 0;

  always @(posedge clk) begin
    exp_t  w, e;
    snap_t cur;
    cur = '{ie: ie, ip: ip, heti: heti, nest: nest, prio: prio_flat, level: level};
    e = '0;
    if (rst) begin
      ms      = M_IDLE;
      prev_ok = 1'b0;
    end else begin
      w = prev_ok ? pick(prev) : '0;
      case (ms)
        M_IDLE:  if (w.valid) begin ms = M_OFFER; e = w; end
        M_OFFER: begin
          if (ack) begin
            ms = M_FLUSH;
            fl = 1;
            if (int'(ack_id) < NL) e.clr[ack_id] = 1'b1;
          end else if (w.valid) e = w;
          else ms = M_IDLE;
        end
        default: begin
          if (fl == 1) fl = 2;
          else if (w.valid) begin ms = M_OFFER; e = w; end
          else ms = M_IDLE;
        end
      endcase
      prev    = cur;
      prev_ok = 1'b1;
    end
    exp_q.push_back(e);
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{valid: irq_valid, id: irq_id, prio: irq_prio, heti: irq_heti,
            nest: irq_nest, clr: ip_clr};
      n_total++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL offer t=%0t got v=%0b id=%0d p=%0d h=%0b n=%0b clr=%h want v=%0b id=%0d p=%0d h=%0b n=%0b clr=%h",
                 $time, a.valid, a.id, a.prio, a.heti, a.nest, a.clr,
                 e.valid, e.id, e.prio, e.heti, e.nest, e.clr);
      end
    end
  end

  task automatic chk_zero(input string name);
    n_total++;
    if ({irq_valid, irq_id, irq_prio, irq_heti, irq_nest, ip_clr} !== '0) begin
      n_bad++;
      $display("FAIL %s got v=%0b id=%0d p=%0d h=%0b n=%0b clr=%h want all zero",
               name, irq_valid, irq_id, irq_prio, irq_heti, irq_nest, ip_clr);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_line(input int n, input bit e, input bit p, input int pr,
                          input bit h, input bit s);
    ie[n] = e; ip[n] = p; prio[n] = PW'(pr); heti[n] = h; nest[n] = s;
  endtask

  task automatic clear_all();
    ie = '0; ip = '0; heti = '0; nest = '0;
    for (int i = 0; i < NL; i++) prio[i] = '0;
  endtask

  // One-cycle claim. The register file drops ip after the claim edge only
  // if the claim hit an offer with an in-range id.
  task automatic do_ack(input int id);
    bit was_offer;
    was_offer = irq_valid;
    ack    = 1'b1;
    ack_id = IW'(id);
    tick(1);
    ack = 1'b0;
    if (was_offer && id < NL) ip[id] = 1'b0;
  endtask

  initial begin
    bit clr_pend;
    int clr_id;
    rst = 1'b1;
    ack = 1'b0;
    ack_id = '0;
    level = '0;
    clear_all();
    #1 chk_zero("reset_state");
    tick(3);
    rst = 1'b0;

    // 1: single line
    set_line(5, 1, 1, 3, 1, 0);
    tick(4);
    // 2: tie then preemption
    clear_all();
    set_line(9, 1, 1, 7, 0, 1);
    set_line(40, 1, 1, 7, 1, 1);
    tick(4);
    prio[40] = 5'd8;
    tick(4);
    // 3: threshold
    clear_all();
    level = 5'd4;
    set_line(12, 1, 1, 4, 1, 1);
    tick(4);
    level = 5'd3;
    tick(4);
    // 4: claim line 12
    do_ack(12);
    tick(5);
    // 5: claim in IDLE, then out-of-range claim in OFFER
    do_ack(12);
    tick(2);
    set_line(20, 1, 1, 5, 0, 0);
    tick(4);
    do_ack(62);
    tick(5);
    // 6: reset during FLUSH
    clear_all();
    level = '0;
    set_line(33, 1, 1, 6, 1, 0);
    set_line(50, 1, 1, 2, 0, 1);
    tick(4);
    ack = 1'b1;
    ack_id = IW'(33);
    tick(1);
    ack = 1'b0;
    ip[33] = 1'b0;
    #5 rst = 1'b1;
    #1 chk_zero("async_reset_flush");
    tick(2);
    rst = 1'b0;
    tick(5);

    // Randomized traffic
    clear_all();
    clr_pend = 1'b0;
    clr_id = 0;
    for (int c = 0; c < 1500; c++) begin
      int n;
      ack = 1'b0;
      if (clr_pend) begin ip[clr_id] = 1'b0; clr_pend = 1'b0; end
      repeat ($urandom_range(0, 2)) begin
        n = $urandom_range(0, NL-1);
        ie[n]   = ($urandom_range(0, 3) != 0);
        ip[n]   = 1'($urandom_range(0, 1));
        prio[n] = PW'($urandom_range(0, 31));
        heti[n] = 1'($urandom_range(0, 1));
        nest[n] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) level = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        ack = 1'b1;
        if (irq_valid && $urandom_range(0, 7) != 0) ack_id = irq_id;
        else ack_id = IW'($urandom_range(0, 63));
        if (irq_valid && int'(ack_id) < NL) begin
          clr_pend = 1'b1;
          clr_id   = int'(ack_id);
        end
      end
      tick(1);
    end
    ack = 1'b0;
    tick(4);

    n_total++;
    if (n_total < 1550) begin
      n_bad++;
      $display("FAIL scoreboard_count got %0d want at least 1550", n_total);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
